mtm_alu_deserializer_p: RTL and testbench
=========================================

Name: mtm_alu_deserializer_p

Overview:
Parametrised successor of the ALU serial input deserializer. Receives one packet on the single-bit line sin: 2*N_BYTES data frames then one control frame. It checks frame structure, CRC-4 and opcode legality, then emits either a one-cycle operand/opcode strobe or a one-cycle error strobe. Sits between the chip serial input pin and the ALU core.

Parameters:
N_BYTES, 4, bytes per operand; legal range 1..16; operand width W = 8*N_BYTES
TIMEOUT_CYC, 64, idle-line cycles allowed between frames of one packet (optional feature only)

Ports:
clk  in  1  system clock; sin sampled every rising edge, one bit per cycle
rst  in  1  asynchronous, active-high reset
sin  in  1  serial input; idle level 1
a_out  out  W  operand A, first N_BYTES data frames, MSB byte first
b_out  out  W  operand B, next N_BYTES data frames
op_out  out  3  opcode from control frame
out_valid  out  1  one-cycle strobe: a_out/b_out/op_out valid
err_flags  out  6  error code, valid when err_valid=1
err_valid  out  1  one-cycle strobe: packet rejected

Behaviour:
- Reset, async on rst=1: all outputs 0, FSM to IDLE, frame counter 0, shift registers 0.
- Frame is 11 bits: start 0, type bit (0 data, 1 control), 8 payload bits MSB first, stop 1.
- Control payload = {1'b0, OP[2:0], CRC[3:0]}.
- FSM states:
  - IDLE: wait for sin=0, then go to TYPE.
  - TYPE: capture the type bit, then go to PAYLOAD.
  - PAYLOAD: capture 8 bits, with the bit counter wrapping at 8, then go to STOP.
  - STOP: check the stop bit. On 1, go to IDLE (data frame) or CHECK (control frame). On 0, go to ERR.
  - CHECK: verify CRC and opcode, then go to OUT or ERR.
  - OUT: output strobe, then go to IDLE.
  - ERR: error strobe, then go to IDLE.
- Frame count rules:
  - A control frame arriving when count != 2*N_BYTES gives ERR_DATA.
  - A data frame arriving when count == 2*N_BYTES gives ERR_DATA.
  - The error is raised at that frame's stop bit.
- CRC-4:
  - Polynomial x^4+x+1, initial value 0.
  - Computed over {B, A, 1'b1, OP}, 2W+4 bits, MSB first.
- Legal opcodes: AND 3'b000, OR 3'b001, ADD 3'b100, SUB 3'b101.
- Error codes: ERR_DATA 6'b100100, ERR_CRC 6'b010010, ERR_OP 6'b001001.
- Error priority: DATA > CRC > OP; only one code is reported.
- Latency: out_valid or err_valid is registered high for exactly one cycle, on the 2nd rising edge after the edge that samples the control-frame stop bit.
- Error detected at a STOP state (framing or count): the strobe rises on the next edge.
- Output hold: a_out, b_out, op_out hold their last good values until the next good packet; they are unchanged on error.
- After OUT or ERR:
  - Frame counter clears and the FSM returns to IDLE.
  - A start bit (sin=0) sampled in the OUT/ERR cycle is ignored.
  - The next packet must begin after IDLE is re-entered.
- Reset mid-packet: partial data is discarded and no strobe is issued.

Optional Feature:
ALU_DES_TIMEOUT_EN
- Defined: counts IDLE cycles while the frame count is in 1..2*N_BYTES. Reaching TIMEOUT_CYC gives ERR_DATA with err_valid on the next edge, and the frame counter clears.
- Undefined: no counter; a partial packet waits indefinitely.

Decomposition:
- Package mtm_alu_des_pkg holds:
  - the FSM state enum;
  - opcode constants;
  - the three error-code constants;
  - the parametrisable CRC-4 function over 2W+4 bits;
  - a frame-type constant.
- Sub-module mtm_alu_frame_rx does bit-level framing. It produces a byte, a type bit, a done strobe and a framing-error strobe.
- The top level handles frame counting, operand assembly, CHECK and the outputs.

Test Plan:
- N_BYTES=4; A=0x00000003, B=0x00000002; control byte 0x46 (ADD, CRC 4'h6) -> out_valid one cycle; a_out=3, b_out=2, op_out=3'b100; err_valid=0.
- Same packet with control byte 0x47 (CRC 4'h7) -> err_valid=1, err_flags=6'b010010; a_out and b_out unchanged.
- Same operands with control byte 0x2C (OP 3'b010, CRC 4'hC) -> err_flags=6'b001001.
- Control frame sent after only 7 data frames -> err_flags=6'b100100 one edge after its stop bit; the next correct packet is accepted.
- Stop bit forced to 0 on data frame 3 -> ERR_DATA strobe; then rst pulsed mid-next-packet -> no strobe, all outputs 0.
- ALU_DES_TIMEOUT_EN defined, TIMEOUT_CYC=64; line held at 1 after 2 data frames -> ERR_DATA after 64 idle cycles; repeat without the macro -> no strobe.

Source files
------------

// File: rtl/mtm_alu_des_pkg.sv
// Shared types, constants and the CRC-4 helper for the ALU serial input deserializer.
package mtm_alu_des_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StType,
    StPayload,
    StStop,
    StCheck,
    StOut,
    StErr
  } state_e;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b100;
  localparam logic [2:0] OpSub = 3'b101;

  localparam logic [5:0] ErrData = 6'b100100;
  localparam logic [5:0] ErrCrc  = 6'b010010;
  localparam logic [5:0] ErrOp   = 6'b001001;

  localparam logic FrameData = 1'b0;
  localparam logic FrameCtl  = 1'b1;

  // Widest CRC input: two 128-bit operands plus marker bit and opcode.
  localparam int CrcMaxBits = 2 * 128 + 4;

  // CRC-4, poly x^4+x+1, init 0, over the low nbits of data, MSB first.
  function automatic logic [3:0] crc4(input logic [CrcMaxBits-1:0] data, input int nbits);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = CrcMaxBits - 1; i >= 0; i--) begin
      if (i < nbits) begin
        fb = c[3] ^ data[i];
        c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      end
    end
    return c;
  endfunction

  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      OpAnd, OpOr, OpAdd, OpSub: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// Bit-level receiver for one 11-bit frame: start, type, 8 payload bits MSB first, stop.
module mtm_alu_frame_rx
  import mtm_alu_des_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sin,
  input  logic       i_hold,
  output logic [7:0] o_byte,
  output logic       o_type,
  output logic       o_done,
  output logic       o_ferr,
  output logic       o_idle
);

  state_e     r_state, w_state_d;
  logic [2:0] r_bit_cnt, w_bit_cnt_d;
  logic [7:0] r_byte, w_byte_d;
  logic       r_type, w_type_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_bit_cnt <= 3'd0;
      r_byte    <= 8'h00;
      r_type    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_byte    <= w_byte_d;
      r_type    <= w_type_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_bit_cnt_d = r_bit_cnt;
    w_byte_d    = r_byte;
    w_type_d    = r_type;
    o_done      = 1'b0;
    o_ferr      = 1'b0;
    case (r_state)
      // A start bit seen while the packet logic is busy is ignored.
      StIdle: begin
        if (!i_hold && !i_sin) w_state_d = StType;
      end
      StType: begin
        w_type_d    = i_sin;
        w_bit_cnt_d = 3'd0;
        w_state_d   = StPayload;
      end
      StPayload: begin
        w_byte_d    = {r_byte[6:0], i_sin};
        w_bit_cnt_d = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) w_state_d = StStop;
      end
      StStop: begin
        o_done    = i_sin;
        o_ferr    = !i_sin;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_byte = r_byte;
  assign o_type = r_type;
  assign o_idle = (r_state == StIdle);

endmodule

// File: rtl/mtm_alu_deserializer_p.sv
// Packet-level deserializer: frame counting, operand assembly, CRC/opcode check, strobes.
// Optional inter-frame idle timeout enabled by defining ALU_DES_TIMEOUT_EN.
module mtm_alu_deserializer_p
  import mtm_alu_des_pkg::*;
#(
  parameter int unsigned N_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  output logic [8*N_BYTES-1:0] a_out,
  output logic [8*N_BYTES-1:0] b_out,
  output logic [2:0]           op_out,
  output logic                 out_valid,
  output logic [5:0]           err_flags,
  output logic                 err_valid
);

  localparam int unsigned W       = 8 * N_BYTES;
  localparam logic [5:0]  NFrames = 6'(2 * N_BYTES);

  logic [7:0] w_rx_byte;
  logic       w_rx_type, w_rx_done, w_rx_ferr, w_rx_idle;

  state_e       r_state, w_state_d;
  logic [5:0]   r_frame_cnt, w_frame_cnt_d;
  logic [2*W-1:0] r_data_sr, w_data_sr_d;
  logic [7:0]   r_ctl, w_ctl_d;
  logic [5:0]   r_err_code, w_err_code_d;

  logic [W-1:0] r_a, r_b;
  logic [2:0]   r_op;
  logic         r_out_valid, r_err_valid;
  logic [5:0]   r_err_flags;

  logic [2*W+3:0] w_crc_in;
  logic [3:0]     w_crc;

  mtm_alu_frame_rx u_frame_rx (
    .clk    (clk),
    .rst    (rst),
    .i_sin  (sin),
    .i_hold (r_state != StIdle),
    .o_byte (w_rx_byte),
    .o_type (w_rx_type),
    .o_done (w_rx_done),
    .o_ferr (w_rx_ferr),
    .o_idle (w_rx_idle)
  );

  // First received bytes sit in the upper half: upper W bits are A, lower W bits are B.
  assign w_crc_in = {r_data_sr[W-1:0], r_data_sr[2*W-1:W], 1'b1, r_ctl[6:4]};
  assign w_crc    = crc4(CrcMaxBits'(w_crc_in), 2 * W + 4);

`ifdef ALU_DES_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  logic [ToW-1:0] r_to_cnt;
  logic           w_to_count, w_to_expire;
  logic           w_unused;

  assign w_to_count  = (r_state == StIdle) && w_rx_idle && sin && (r_frame_cnt != 6'd0);
  assign w_to_expire = w_to_count && (r_to_cnt == ToW'(TIMEOUT_CYC - 1));
  assign w_unused    = r_ctl[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_to_count && !w_to_expire) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{r_ctl[7], w_rx_idle, TIMEOUT_CYC};
`endif

  always_comb begin
    w_state_d     = r_state;
    w_frame_cnt_d = r_frame_cnt;
    w_data_sr_d   = r_data_sr;
    w_ctl_d       = r_ctl;
    w_err_code_d  = r_err_code;
    case (r_state)
      StIdle: begin
        if (w_rx_ferr) begin
          w_state_d    = StErr;
          w_err_code_d = ErrData;
        end else if (w_rx_done) begin
          if (w_rx_type == FrameCtl) begin
            if (r_frame_cnt != NFrames) begin
              w_state_d    = StErr;
              w_err_code_d = ErrData;
            end else begin
              w_ctl_d   = w_rx_byte;
              w_state_d = StCheck;
            end
          end else if (r_frame_cnt == NFrames) begin
            w_state_d    = StErr;
            w_err_code_d = ErrData;
          end else begin
            w_data_sr_d   = {r_data_sr[2*W-9:0], w_rx_byte};
            w_frame_cnt_d = r_frame_cnt + 6'd1;
          end
        end
`ifdef ALU_DES_TIMEOUT_EN
        else if (w_to_expire) begin
          w_state_d     = StErr;
          w_err_code_d  = ErrData;
          w_frame_cnt_d = 6'd0;
        end
`endif
      end
      StCheck: begin
        if (w_crc != r_ctl[3:0]) begin
          w_state_d    = StErr;
          w_err_code_d = ErrCrc;
        end else if (!is_legal_op(r_ctl[6:4])) begin
          w_state_d    = StErr;
          w_err_code_d = ErrOp;
        end else begin
          w_state_d = StOut;
        end
      end
      StOut, StErr: begin
        w_state_d     = StIdle;
        w_frame_cnt_d = 6'd0;
      end
      default: begin
        w_state_d     = StIdle;
        w_frame_cnt_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_frame_cnt <= 6'd0;
      r_data_sr   <= '0;
      r_ctl       <= 8'h00;
      r_err_code  <= 6'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 3'd0;
      r_out_valid <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_flags <= 6'd0;
    end else begin
      r_state     <= w_state_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_data_sr   <= w_data_sr_d;
      r_ctl       <= w_ctl_d;
      r_err_code  <= w_err_code_d;
      r_out_valid <= (r_state == StOut);
      r_err_valid <= (r_state == StErr);
      r_err_flags <= (r_state == StErr) ? r_err_code : 6'd0;
      if (r_state == StOut) begin
        r_a  <= r_data_sr[2*W-1:W];
        r_b  <= r_data_sr[W-1:0];
        r_op <= r_ctl[6:4];
      end
    end
  end

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign op_out    = r_op;
  assign out_valid = r_out_valid;
  assign err_flags = r_err_flags;
  assign err_valid = r_err_valid;

endmodule

// File: tb/tb_mtm_alu_deserializer_p.sv
// Scoreboard bench for mtm_alu_deserializer_p (N_BYTES=4); covers ALU_DES_TIMEOUT_EN both ways.
module tb_mtm_alu_deserializer_p;

  localparam logic [5:0] EData = 6'b100100;
  localparam logic [5:0] ECrc  = 6'b010010;
  localparam logic [5:0] EOp   = 6'b001001;

  typedef struct {
    bit          is_err;
    logic [5:0]  flags;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    int          due_lo;
    int          due_hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] a_out, b_out;
  logic [2:0]  op_out;
  logic        out_valid, err_valid;
  logic [5:0]  err_flags;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_strobes = 0;
  int   last_stop = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [31:0] hold_a = '0, hold_b = '0;
  logic [2:0]  hold_op = '0;

  mtm_alu_deserializer_p #(
    .N_BYTES     (4),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .a_out     (a_out),
    .b_out     (b_out),
    .op_out    (op_out),
    .out_valid (out_valid),
    .err_flags (err_flags),
    .err_valid (err_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, " a_out"}, 64'(a_out), 64'd0);
    chk({pfx, " b_out"}, 64'(b_out), 64'd0);
    chk({pfx, " op_out"}, 64'(op_out), 64'd0);
    chk({pfx, " out_valid"}, 64'(out_valid), 64'd0);
    chk({pfx, " err_valid"}, 64'(err_valid), 64'd0);
    chk({pfx, " err_flags"}, 64'(err_flags), 64'd0);
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
    last_stop = cyc;
  endtask

  // Sends the first n data frames of {a, b}, MSB byte first; frames beyond 8 carry 0x00.
  task automatic send_operands(input logic [31:0] a, input logic [31:0] b, input int n);
    logic [63:0] ab;
    logic [7:0]  by;
    ab = {a, b};
    for (int k = 0; k < n; k++) begin
      by = 8'h00;
      if (k < 8) by = ab[63-8*k -: 8];
      send_frame(1'b0, by, 1'b1);
    end
  endtask

  task automatic push_ok(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    q.push_back('{1'b0, 6'd0, a, b, op, last_stop + 2, last_stop + 2});
    hold_a  = a;
    hold_b  = b;
    hold_op = op;
  endtask

  task automatic push_err(input logic [5:0] f, input int lo, input int hi);
    q.push_back('{1'b1, f, hold_a, hold_b, hold_op, lo, hi});
  endtask

  task automatic good_packet(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl,
                             input logic [2:0] op);
    send_operands(a, b, 8);
    send_frame(1'b1, ctl, 1'b1);
    push_ok(a, b, op);
    send_idle(4);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    sin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold_a  = '0;
    hold_b  = '0;
    hold_op = '0;
  endtask

  // Monitor: pops the scoreboard on every strobe; flags strobes that are missing or unexpected.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid || err_valid) begin
        n_strobes++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got out_valid=%b err_valid=%b expected none (cycle %0d)",
                   out_valid, err_valid, cyc);
        end else begin
          mon_e = q.pop_front();
          n_cmp++;
          if (cyc < mon_e.due_lo || cyc > mon_e.due_hi) begin
            n_bad++;
            $display("FAIL strobe_time: got cycle %0d expected %0d..%0d", cyc, mon_e.due_lo,
                     mon_e.due_hi);
          end
          chk("strobe_kind", 64'({out_valid, err_valid}), mon_e.is_err ? 64'd1 : 64'd2);
          if (mon_e.is_err) chk("err_flags", 64'(err_flags), 64'(mon_e.flags));
          chk("a_out", 64'(a_out), 64'(mon_e.a));
          chk("b_out", 64'(b_out), 64'(mon_e.b));
          chk("op_out", 64'(op_out), 64'(mon_e.op));
        end
      end else if (q.size() > 0 && cyc > q[0].due_hi) begin
        mon_e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_strobe: got none by cycle %0d expected is_err=%0b by cycle %0d",
                 cyc, mon_e.is_err, mon_e.due_hi);
      end
    end
  end

  logic [7:0] ctl_tab [3] = '{8'h0A, 8'h19, 8'h55};
  logic [2:0] op_tab  [3] = '{3'b000, 3'b001, 3'b101};
  int         s0;

  initial begin
    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");
    send_idle(4);

    good_packet(32'h3, 32'h2, 8'h46, 3'b100);

    send_operands(32'h3, 32'h2, 8);
    send_frame(1'b1, 8'h47, 1'b1);
    push_err(ECrc, last_stop + 2, last_stop + 2);
    send_idle(4);

    send_operands(32'h3, 32'h2, 8);
    send_frame(1'b1, 8'h2C, 1'b1);
    push_err(EOp, last_stop + 2, last_stop + 2);
    send_idle(4);

    // Control frame after only 7 data frames.
    send_operands(32'h3, 32'h2, 7);
    send_frame(1'b1, 8'h46, 1'b1);
    push_err(EData, last_stop + 1, last_stop + 1);
    send_idle(4);
    good_packet(32'h1, 32'h0, 8'h42, 3'b100);
    good_packet(32'h0100_0000, 32'h0, 8'h43, 3'b100);

    for (int i = 0; i < 3; i++) good_packet(32'h3, 32'h2, ctl_tab[i], op_tab[i]);

    // Ninth data frame.
    send_operands(32'h3, 32'h2, 9);
    push_err(EData, last_stop + 1, last_stop + 1);
    send_idle(4);
    good_packet(32'h3, 32'h2, 8'h46, 3'b100);

    // Stop bit low on data frame 3.
    send_operands(32'h3, 32'h2, 2);
    send_frame(1'b0, 8'h00, 1'b0);
    push_err(EData, last_stop + 1, last_stop + 1);
    send_idle(4);

    // Reset in the middle of the next packet.
    send_operands(32'h3, 32'h2, 3);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    pulse_reset();
    check_zero("mid_reset");
    send_idle(20);
    good_packet(32'h1, 32'h0, 8'h42, 3'b100);

    send_operands(32'h3, 32'h2, 2);
`ifdef ALU_DES_TIMEOUT_EN
    push_err(EData, last_stop + 64, last_stop + 66);
    send_idle(80);
    good_packet(32'h3, 32'h2, 8'h46, 3'b100);
`else
    s0 = n_strobes;
    send_idle(150);
    chk("no_timeout_strobe", 64'(n_strobes - s0), 64'd0);
    pulse_reset();
    check_zero("end_reset");
`endif

    for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
